// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: converts an angle command into a 20 ms frame with a
// 0.5-2.5 ms pulse, slewing the applied angle toward the command once per frame.
module servo_pwm_gen #(
  parameter int PERIOD_CYCLES    = 1000000,
  parameter int MIN_PULSE_CYCLES = 25000,
  parameter int CYCLES_PER_DEG   = 556,
  parameter int MAX_ANGLE        = 180,
  parameter int SLEW_STEP        = 2,
  parameter int INIT_ANGLE       = 90
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic [7:0] angle_in,
  output logic       pwm_out,
  output logic [7:0] cur_angle,
  output logic       frame_start,
  output logic       at_target
);

  localparam int CW = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST_CNT   = CW'(PERIOD_CYCLES - 1);
  localparam logic [CW-1:0] MIN_PULSE  = CW'(MIN_PULSE_CYCLES);
  localparam logic [CW-1:0] PER_DEG    = CW'(CYCLES_PER_DEG);
  localparam logic [CW-1:0] INIT_PULSE = CW'(MIN_PULSE_CYCLES + INIT_ANGLE * CYCLES_PER_DEG);
  localparam logic [7:0]    MAX_ANG    = 8'(MAX_ANGLE);
  localparam logic [7:0]    STEP       = 8'(SLEW_STEP);
  localparam logic [7:0]    INIT_ANG   = 8'(INIT_ANGLE);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pulse_q, pulse_d;
  logic [7:0]    cur_q, cur_d;
  logic [7:0]    tgt_q, tgt_d;
  logic          pwm_q, pwm_d;
  logic          fs_q, fs_d;
  logic          at_q, at_d;

  logic [7:0]    clampedAngle;
  logic [7:0]    angleDiff;
  logic [7:0]    stepSize;
  logic [7:0]    nextCur;
  logic          movingUp;
  logic [CW-1:0] cntInc;

  // Slew limiter: step toward the clamped command; a zero step size means jump directly.
  always_comb begin
    clampedAngle = (angle_in > MAX_ANG) ? MAX_ANG : angle_in;
    movingUp     = (clampedAngle >= cur_q);
    angleDiff    = movingUp ? (clampedAngle - cur_q) : (cur_q - clampedAngle);
    stepSize     = ((STEP == 8'd0) || (angleDiff < STEP)) ? angleDiff : STEP;
    nextCur      = movingUp ? (cur_q + stepSize) : (cur_q - stepSize);
    cntInc       = cnt_q + CW'(1);
  end

  // Command, angle and pulse width are only updated on the frame boundary edge.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    pwm_d   = pwm_q;
    fs_d    = fs_q;
    at_d    = at_q;
    if (!enable) begin
      cnt_d = LAST_CNT;
      pwm_d = 1'b0;
      fs_d  = 1'b0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d   = '0;
      tgt_d   = clampedAngle;
      cur_d   = nextCur;
      pulse_d = MIN_PULSE + CW'(nextCur) * PER_DEG;
      fs_d    = 1'b1;
      pwm_d   = 1'b1;
      at_d    = (nextCur == clampedAngle);
    end else begin
      cnt_d = cntInc;
      fs_d  = 1'b0;
      pwm_d = (cntInc < pulse_q);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= LAST_CNT;
      pulse_q <= INIT_PULSE;
      cur_q   <= INIT_ANG;
      tgt_q   <= INIT_ANG;
      pwm_q   <= 1'b0;
      fs_q    <= 1'b0;
      at_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      pwm_q   <= pwm_d;
      fs_q    <= fs_d;
      at_q    <= at_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign cur_angle   = cur_q;
  assign frame_start = fs_q;
  assign at_target   = at_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with short frames; a second instance with
// no slew limit covers the direct-jump case.
module tb_servo_pwm_gen;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] angle_in = 8'd90;
  logic       pwm_out, frame_start, at_target;
  logic [7:0] cur_angle;

  logic       enable2 = 1'b0;
  logic [7:0] angle2 = 8'd90;
  logic       pwm2, fs2, at2;
  logic [7:0] cur2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .PERIOD_CYCLES(1000), .MIN_PULSE_CYCLES(50), .CYCLES_PER_DEG(2),
    .MAX_ANGLE(180), .SLEW_STEP(5), .INIT_ANGLE(90)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .angle_in(angle_in),
    .pwm_out(pwm_out), .cur_angle(cur_angle), .frame_start(frame_start),
    .at_target(at_target)
  );

  servo_pwm_gen #(
    .PERIOD_CYCLES(1000), .MIN_PULSE_CYCLES(50), .CYCLES_PER_DEG(2),
    .MAX_ANGLE(180), .SLEW_STEP(0), .INIT_ANGLE(90)
  ) dutJump (
    .clk(clk), .nrst(nrst), .enable(enable2), .angle_in(angle2),
    .pwm_out(pwm2), .cur_angle(cur2), .frame_start(fs2),
    .at_target(at2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int getPwm(input int which);
    return (which == 0) ? int'(pwm_out) : int'(pwm2);
  endfunction

  function automatic int getFs(input int which);
    return (which == 0) ? int'(frame_start) : int'(fs2);
  endfunction

  function automatic int getCur(input int which);
    return (which == 0) ? int'(cur_angle) : int'(cur2);
  endfunction

  function automatic int getAt(input int which);
    return (which == 0) ? int'(at_target) : int'(at2);
  endfunction

  // Called on the negedge where frame_start is seen; returns at the next frame start.
  task automatic frameCheck(input string tag, input int which, input int expCur,
                            input int expAt, input int expWidth);
    int width;
    int period;
    bit seen;
    checkOutput({tag, "_fs"}, getFs(which), 1);
    checkOutput({tag, "_cur"}, getCur(which), expCur);
    checkOutput({tag, "_at"}, getAt(which), expAt);
    width  = getPwm(which);
    period = 1;
    seen   = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge clk);
      if (getFs(which) == 1) seen = 1'b1;
      else begin
        period++;
        width += getPwm(which);
      end
    end
    checkOutput({tag, "_width"}, width, expWidth);
    checkOutput({tag, "_period"}, seen ? period : -1, 1000);
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] ang);
    enable   = en;
    angle_in = ang;
  endtask

  initial begin
    int idleHits;
    int c;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_pwm", int'(pwm_out), 0);
    checkOutput("rst_fs", int'(frame_start), 0);
    checkOutput("rst_cur", int'(cur_angle), 90);
    checkOutput("rst_at", int'(at_target), 1);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_fs", int'(frame_start), 0);
    checkOutput("idle_pwm", int'(pwm_out), 0);

    // Test 1: first frame one edge after enable
    applyStimulus(1'b1, 8'd90);
    @(negedge clk);
    frameCheck("t1_f1", 0, 90, 1, 230);

    // Test 4: mid-frame glitch on angle_in is ignored
    fork
      frameCheck("t4_f2", 0, 90, 1, 230);
      begin
        repeat (200) @(negedge clk);
        angle_in = 8'd0;
        repeat (300) @(negedge clk);
        angle_in = 8'd90;
      end
    join
    frameCheck("t4_f3", 0, 90, 1, 230);

    // Test 2: slew 90 -> 110
    angle_in = 8'd110;
    frameCheck("t2_hold", 0, 90, 1, 230);
    for (int i = 1; i <= 4; i++)
      frameCheck($sformatf("t2_s%0d", i), 0, 90 + 5 * i, (i == 4) ? 1 : 0, 50 + 2 * (90 + 5 * i));

    // Test 3: over-range command clamps to 180
    angle_in = 8'd200;
    frameCheck("t3_hold", 0, 110, 1, 270);
    for (int k = 1; k <= 14; k++)
      frameCheck($sformatf("t3_s%0d", k), 0, 110 + 5 * k, (k == 14) ? 1 : 0, 50 + 2 * (110 + 5 * k));

    // Test 5: drop enable mid-pulse at cnt=100, then resume slewing from 180
    repeat (100) @(negedge clk);
    checkOutput("t5_pwm_before", int'(pwm_out), 1);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("t5_pwm_cut", int'(pwm_out), 0);
    idleHits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_start || pwm_out) idleHits++;
    end
    checkOutput("t5_idle_activity", idleHits, 0);
    checkOutput("t5_idle_cur", int'(cur_angle), 180);
    applyStimulus(1'b1, 8'd150);
    @(negedge clk);
    frameCheck("t5_resume", 0, 175, 0, 400);

    // Test 6: async reset mid-pulse at cnt=120
    repeat (120) @(negedge clk);
    checkOutput("t6_pwm_before", int'(pwm_out), 1);
    #1 nrst = 1'b0;
    #1;
    checkOutput("t6_pwm_async", int'(pwm_out), 0);
    checkOutput("t6_cur", int'(cur_angle), 90);
    checkOutput("t6_at", int'(at_target), 1);
    checkOutput("t6_fs", int'(frame_start), 0);
    angle_in = 8'd90;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    frameCheck("t6_post", 0, 90, 1, 230);

    // Test 5b: no slew limit, 90 -> 150 in one frame
    enable2 = 1'b1;
    c = 0;
    while (fs2 !== 1'b1 && c < 5) begin
      @(negedge clk);
      c++;
    end
    checkOutput("t5b_latency", c, 1);
    angle2 = 8'd150;
    frameCheck("t5b_first", 1, 90, 1, 230);
    frameCheck("t5b_jump", 1, 150, 1, 350);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
